// File: rtl/mem_stage_if.sv
// Pipeline bus around the MEM stage: the EX->MEM instruction handshake and
// the MEM->WB / MEM->ID bundles. The MEM stage uses the slave view; the
// surrounding pipeline (or a bench) drives it through the master view.
interface mem_stage_if;
    // EX -> MEM
    logic        es2ms_valid;
    logic [31:0] es_pc;
    logic [38:0] es_rf_zip;
    logic [4:0]  es_ld_op;
    logic        ms_allowin;
    // MEM -> WB
    logic        ws_allowin;
    logic        ms2ws_valid;
    logic [31:0] ms_pc;
    logic [37:0] ms_rf_zip;
    // MEM -> ID forwarding
    logic [37:0] ms_fwd_zip;

    modport slave (
        input  es2ms_valid,
        input  es_pc,
        input  es_rf_zip,
        input  es_ld_op,
        input  ws_allowin,
        output ms_allowin,
        output ms2ws_valid,
        output ms_pc,
        output ms_rf_zip,
        output ms_fwd_zip
    );

    modport master (
        output es2ms_valid,
        output es_pc,
        output es_rf_zip,
        output es_ld_op,
        output ws_allowin,
        input  ms_allowin,
        input  ms2ws_valid,
        input  ms_pc,
        input  ms_rf_zip,
        input  ms_fwd_zip
    );
endinterface

// File: rtl/mem_stage.sv
// MEM stage of the five-stage pipeline. Latches one instruction per EX
// handshake, aligns and extends the synchronous data-SRAM read data for
// loads, and produces the register-file write bundle for WB plus a
// forwarding bundle for decode. The SRAM read data is only valid in the
// first cycle an instruction sits in MEM, so it is captured into a buffer
// that keeps the load result stable for as long as WB stalls us.
module mem_stage (
    input  logic              clk,
    input  logic              resetn,
    input  logic [31:0]       data_sram_rdata,
    mem_stage_if.slave        bus
);

    // ---------------------------------------------------------------
    // Helpers
    // ---------------------------------------------------------------
    function automatic logic [31:0] ext_byte(input logic [7:0] b, input logic sgn);
        return {{24{sgn & b[7]}}, b};
    endfunction

    function automatic logic [31:0] ext_half(input logic [15:0] h, input logic sgn);
        return {{16{sgn & h[15]}}, h};
    endfunction

    function automatic logic [7:0] pick_byte(input logic [31:0] w, input logic [1:0] off);
        logic [7:0] b;
        case (off)
            2'd0:    b = w[7:0];
            2'd1:    b = w[15:8];
            2'd2:    b = w[23:16];
            2'd3:    b = w[31:24];
            default: b = 8'h00;
        endcase
        return b;
    endfunction

    function automatic logic [15:0] pick_half(input logic [31:0] w, input logic hi);
        return hi ? w[31:16] : w[15:0];
    endfunction

    // ---------------------------------------------------------------
    // Handshake
    // ---------------------------------------------------------------
    logic        ms_valid_r;
    logic        ms_ready_go_s;
    logic        ms_allowin_s;
    logic        accept_s;

    assign ms_ready_go_s = 1'b1;
    assign ms_allowin_s  = ~ms_valid_r | (ms_ready_go_s & bus.ws_allowin);
    assign accept_s      = bus.es2ms_valid & ms_allowin_s;

    // ---------------------------------------------------------------
    // Payload registers
    // ---------------------------------------------------------------
    logic [31:0] pc_r;
    logic        res_from_mem_r;
    logic        rf_we_r;
    logic [4:0]  rf_waddr_r;
    logic [31:0] alu_result_r;
    logic [4:0]  ld_op_r;

    // Read-data buffer
    logic [31:0] rdata_buf_r;
    logic        rdata_held_r;

    // Valid bit: reloaded from EX whenever the stage can take a new slot
    always_ff @(posedge clk) begin
        if (!resetn) begin
            ms_valid_r <= 1'b0;
        end else if (ms_allowin_s) begin
            ms_valid_r <= bus.es2ms_valid;
        end else begin
            ms_valid_r <= ms_valid_r;
        end
    end

    // Payload capture on a real handshake only; bubbles leave stale values
    always_ff @(posedge clk) begin
        if (!resetn) begin
            pc_r           <= 32'h0000_0000;
            res_from_mem_r <= 1'b0;
            rf_we_r        <= 1'b0;
            rf_waddr_r     <= 5'd0;
            alu_result_r   <= 32'h0000_0000;
            ld_op_r        <= 5'b00000;
        end else if (accept_s) begin
            pc_r           <= bus.es_pc;
            res_from_mem_r <= bus.es_rf_zip[38];
            rf_we_r        <= bus.es_rf_zip[37];
            rf_waddr_r     <= bus.es_rf_zip[36:32];
            alu_result_r   <= bus.es_rf_zip[31:0];
            ld_op_r        <= bus.es_ld_op;
        end else begin
            pc_r           <= pc_r;
            res_from_mem_r <= res_from_mem_r;
            rf_we_r        <= rf_we_r;
            rf_waddr_r     <= rf_waddr_r;
            alu_result_r   <= alu_result_r;
            ld_op_r        <= ld_op_r;
        end
    end

    // Capture the one-cycle SRAM data at the end of the instruction's first MEM cycle
    always_ff @(posedge clk) begin
        if (!resetn) begin
            rdata_buf_r  <= 32'h0000_0000;
            rdata_held_r <= 1'b0;
        end else if (accept_s) begin
            rdata_buf_r  <= rdata_buf_r;
            rdata_held_r <= 1'b0;
        end else if (ms_valid_r && !rdata_held_r) begin
            rdata_buf_r  <= data_sram_rdata;
            rdata_held_r <= 1'b1;
        end else begin
            rdata_buf_r  <= rdata_buf_r;
            rdata_held_r <= rdata_held_r;
        end
    end

    // ---------------------------------------------------------------
    // Load alignment
    // ---------------------------------------------------------------
    logic [31:0] word_s;
    logic [1:0]  off_s;
    logic [7:0]  byte_s;
    logic [15:0] half_s;
    logic [31:0] load_val_s;
    logic [31:0] rf_wdata_s;

    assign word_s = rdata_held_r ? rdata_buf_r : data_sram_rdata;
    assign off_s  = alu_result_r[1:0];
    assign byte_s = pick_byte(word_s, off_s);
    assign half_s = pick_half(word_s, off_s[1]);

    // Select and extend the loaded value by load type (ld_op is one-hot)
    always_comb begin
        load_val_s = word_s;
        if (ld_op_r[4]) begin
            load_val_s = word_s;
        end else if (ld_op_r[3]) begin
            load_val_s = ext_half(half_s, 1'b1);
        end else if (ld_op_r[2]) begin
            load_val_s = ext_half(half_s, 1'b0);
        end else if (ld_op_r[1]) begin
            load_val_s = ext_byte(byte_s, 1'b1);
        end else if (ld_op_r[0]) begin
            load_val_s = ext_byte(byte_s, 1'b0);
        end else begin
            load_val_s = word_s;
        end
    end

    // Choose between memory result and ALU result for the register write
    always_comb begin
        rf_wdata_s = alu_result_r;
        if (res_from_mem_r) begin
            rf_wdata_s = load_val_s;
        end else begin
            rf_wdata_s = alu_result_r;
        end
    end

    // ---------------------------------------------------------------
    // Outputs
    // ---------------------------------------------------------------
    assign bus.ms_allowin  = ms_allowin_s;
    assign bus.ms2ws_valid = ms_valid_r & ms_ready_go_s;
    assign bus.ms_pc       = pc_r;
    // WB qualifies write-enable with its own valid; decode needs it qualified here
    assign bus.ms_rf_zip   = {rf_we_r, rf_waddr_r, rf_wdata_s};
    assign bus.ms_fwd_zip  = {rf_we_r & ms_valid_r, rf_waddr_r, rf_wdata_s};

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: table of single-instruction vectors for the
// load alignment paths, then hand-written stall, stream and reset sequences.
module tb_mem_stage;

    localparam logic [4:0] OP_NONE = 5'b00000;
    localparam logic [4:0] OP_W    = 5'b10000;
    localparam logic [4:0] OP_H    = 5'b01000;
    localparam logic [4:0] OP_HU   = 5'b00100;
    localparam logic [4:0] OP_B    = 5'b00010;
    localparam logic [4:0] OP_BU   = 5'b00001;

    logic        clk;
    logic        resetn;
    logic [31:0] data_sram_rdata;

    mem_stage_if bus ();

    mem_stage dut (
        .clk             (clk),
        .resetn          (resetn),
        .data_sram_rdata (data_sram_rdata),
        .bus             (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic        res_from_mem;
        logic        rf_we;
        logic [4:0]  waddr;
        logic [31:0] addr;
        logic [4:0]  ld_op;
        logic [31:0] rdata;
        logic [31:0] exp_wdata;
    } vec_t;

    vec_t vecs [12];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive_es(input logic v, input logic [31:0] pc, input logic rfm,
                            input logic we, input logic [4:0] wa, input logic [31:0] addr,
                            input logic [4:0] op);
        bus.es2ms_valid = v;
        bus.es_pc       = pc;
        bus.es_rf_zip   = {rfm, we, wa, addr};
        bus.es_ld_op    = op;
    endtask

    initial begin
        vecs[0]  = '{1'b0, 1'b1, 5'd5,  32'h1234_5678, OP_NONE, 32'hAAAA_5555, 32'h1234_5678};
        vecs[1]  = '{1'b1, 1'b1, 5'd6,  32'h1C00_0103, OP_B,    32'h80FF_1234, 32'hFFFF_FF80};
        vecs[2]  = '{1'b1, 1'b1, 5'd7,  32'h1C00_0103, OP_BU,   32'h80FF_1234, 32'h0000_0080};
        vecs[3]  = '{1'b1, 1'b1, 5'd8,  32'h1C00_0101, OP_B,    32'h80FF_1234, 32'h0000_0012};
        vecs[4]  = '{1'b1, 1'b1, 5'd9,  32'h1C00_0102, OP_H,    32'h9ABC_0001, 32'hFFFF_9ABC};
        vecs[5]  = '{1'b1, 1'b1, 5'd10, 32'h1C00_0102, OP_HU,   32'h9ABC_0001, 32'h0000_9ABC};
        vecs[6]  = '{1'b1, 1'b1, 5'd11, 32'h1C00_0102, OP_W,    32'h9ABC_0001, 32'h9ABC_0001};
        vecs[7]  = '{1'b1, 1'b1, 5'd12, 32'h1C00_0103, OP_H,    32'h9ABC_0001, 32'hFFFF_9ABC};
        vecs[8]  = '{1'b1, 1'b1, 5'd13, 32'h1C00_0100, OP_H,    32'h0001_8001, 32'hFFFF_8001};
        vecs[9]  = '{1'b1, 1'b1, 5'd14, 32'h1C00_0102, OP_B,    32'h007F_0000, 32'h0000_007F};
        vecs[10] = '{1'b1, 1'b1, 5'd15, 32'h1C00_0101, OP_NONE, 32'h1357_2468, 32'h1357_2468};
        vecs[11] = '{1'b1, 1'b0, 5'd0,  32'h1C00_0100, OP_BU,   32'h0000_00FF, 32'h0000_00FF};

        // ---------------- reset ----------------
        resetn          = 1'b0;
        data_sram_rdata = 32'h0000_0000;
        bus.ws_allowin  = 1'b1;
        drive_es(1'b0, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0, OP_NONE);
        @(negedge clk);
        @(negedge clk);
        #1;
        check("reset_allowin",  {63'd0, bus.ms_allowin},  64'd1);
        check("reset_valid",    {63'd0, bus.ms2ws_valid}, 64'd0);
        check("reset_pc",       {32'd0, bus.ms_pc},       64'd0);
        check("reset_rf_zip",   {26'd0, bus.ms_rf_zip},   64'd0);
        check("reset_fwd_zip",  {26'd0, bus.ms_fwd_zip},  64'd0);
        resetn = 1'b1;

        // ---------------- table vectors ----------------
        for (int i = 0; i < 12; i++) begin
            drive_es(1'b1, 32'h1C00_0000 + 32'(4 * i), vecs[i].res_from_mem, vecs[i].rf_we,
                     vecs[i].waddr, vecs[i].addr, vecs[i].ld_op);
            @(negedge clk);
            bus.es2ms_valid = 1'b0;
            data_sram_rdata = vecs[i].rdata;
            #1;
            check($sformatf("vec%0d_valid", i), {63'd0, bus.ms2ws_valid}, 64'd1);
            check($sformatf("vec%0d_pc", i), {32'd0, bus.ms_pc}, {32'd0, 32'h1C00_0000 + 32'(4 * i)});
            check($sformatf("vec%0d_rf_zip", i), {26'd0, bus.ms_rf_zip},
                  {26'd0, vecs[i].rf_we, vecs[i].waddr, vecs[i].exp_wdata});
            check($sformatf("vec%0d_fwd_zip", i), {26'd0, bus.ms_fwd_zip},
                  {26'd0, vecs[i].rf_we, vecs[i].waddr, vecs[i].exp_wdata});
        end
        drive_es(1'b0, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0, OP_NONE);
        @(negedge clk);

        // ---------------- stalled load keeps its data ----------------
        drive_es(1'b1, 32'h1C00_0200, 1'b1, 1'b1, 5'd9, 32'h1C00_0100, OP_W);
        bus.ws_allowin = 1'b0;
        @(negedge clk);
        data_sram_rdata = 32'hDEAD_BEEF;
        drive_es(1'b1, 32'h1C00_0204, 1'b1, 1'b1, 5'd10, 32'h1C00_0104, OP_W);
        #1;
        check("stall_first_wdata", {32'd0, bus.ms_rf_zip[31:0]}, {32'd0, 32'hDEAD_BEEF});
        check("stall_first_allowin", {63'd0, bus.ms_allowin}, 64'd0);
        for (int s = 0; s < 3; s++) begin
            @(negedge clk);
            data_sram_rdata = 32'h0000_0000;
            #1;
            check($sformatf("stall%0d_wdata", s), {32'd0, bus.ms_rf_zip[31:0]}, {32'd0, 32'hDEAD_BEEF});
            check($sformatf("stall%0d_allowin", s), {63'd0, bus.ms_allowin}, 64'd0);
            check($sformatf("stall%0d_pc", s), {32'd0, bus.ms_pc}, {32'd0, 32'h1C00_0200});
        end
        bus.ws_allowin = 1'b1;
        #1;
        check("release_allowin", {63'd0, bus.ms_allowin}, 64'd1);
        check("release_valid",   {63'd0, bus.ms2ws_valid}, 64'd1);
        check("release_rf_zip",  {26'd0, bus.ms_rf_zip}, {26'd0, 1'b1, 5'd9, 32'hDEAD_BEEF});
        // leave and enter on the same edge; the new load must see fresh SRAM data
        @(negedge clk);
        data_sram_rdata = 32'h1122_3344;
        drive_es(1'b0, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0, OP_NONE);
        #1;
        check("next_pc",     {32'd0, bus.ms_pc}, {32'd0, 32'h1C00_0204});
        check("next_rf_zip", {26'd0, bus.ms_rf_zip}, {26'd0, 1'b1, 5'd10, 32'h1122_3344});
        check("next_valid",  {63'd0, bus.ms2ws_valid}, 64'd1);
        @(negedge clk);
        data_sram_rdata = 32'h0000_0000;
        #1;
        check("drain_valid", {63'd0, bus.ms2ws_valid}, 64'd0);

        // ---------------- back-to-back stream, then bubble ----------------
        for (int k = 0; k < 4; k++) begin
            drive_es(1'b1, 32'h1C00_0300 + 32'(4 * k), 1'b0, 1'b1, 5'(k + 1),
                     32'hA000_0000 + 32'(k), OP_NONE);
            @(negedge clk);
            #1;
            check($sformatf("stream%0d_valid", k), {63'd0, bus.ms2ws_valid}, 64'd1);
            check($sformatf("stream%0d_pc", k), {32'd0, bus.ms_pc}, {32'd0, 32'h1C00_0300 + 32'(4 * k)});
            check($sformatf("stream%0d_rf_zip", k), {26'd0, bus.ms_rf_zip},
                  {26'd0, 1'b1, 5'(k + 1), 32'hA000_0000 + 32'(k)});
        end
        drive_es(1'b0, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0, OP_NONE);
        @(negedge clk);
        #1;
        check("bubble_valid",   {63'd0, bus.ms2ws_valid},  64'd0);
        check("bubble_fwd_we",  {63'd0, bus.ms_fwd_zip[37]}, 64'd0);
        check("bubble_allowin", {63'd0, bus.ms_allowin},   64'd1);

        // ---------------- reset during a stalled load ----------------
        drive_es(1'b1, 32'h1C00_0400, 1'b1, 1'b1, 5'd3, 32'h1C00_0108, OP_W);
        bus.ws_allowin = 1'b0;
        @(negedge clk);
        data_sram_rdata = 32'hCAFE_F00D;
        drive_es(1'b0, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0, OP_NONE);
        #1;
        check("rst_stall_wdata", {32'd0, bus.ms_rf_zip[31:0]}, {32'd0, 32'hCAFE_F00D});
        @(negedge clk);
        data_sram_rdata = 32'h0000_0000;
        resetn = 1'b0;
        @(negedge clk);
        #1;
        check("rst_stall_allowin", {63'd0, bus.ms_allowin},  64'd1);
        check("rst_stall_valid",   {63'd0, bus.ms2ws_valid}, 64'd0);
        check("rst_stall_pc",      {32'd0, bus.ms_pc},       64'd0);
        check("rst_stall_rf_zip",  {26'd0, bus.ms_rf_zip},   64'd0);
        check("rst_stall_fwd_zip", {26'd0, bus.ms_fwd_zip},  64'd0);
        resetn = 1'b1;
        bus.ws_allowin = 1'b1;
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access (MEM) stage of the five-stage in-order pipeline, between the execute stage and the write-back stage. It latches one instruction per handshake from EX, selects and aligns the synchronous data-SRAM read data for loads (byte/half/word, sign- or zero-extended), and hands the register-file write bundle to WB. It also drives a forwarding bundle back to the decode stage. While stalled by WB, it buffers the load data so the one-cycle-valid SRAM read data is not lost.

## Interface
- No parameters.
- `clk`  in  1  sole clock; all state updates on posedge.
- `resetn`  in  1  synchronous, active-low reset.
- `ms_allowin`  out  1  MEM can accept an instruction this cycle.
- `es2ms_valid`  in  1  EX presents a valid instruction.
- `es_pc`  in  32  PC of the EX instruction.
- `es_rf_zip`  in  39  {es_res_from_mem, es_rf_we, es_rf_waddr[4:0], es_alu_result[31:0]}; alu_result is the data address for loads.
- `es_ld_op`  in  5  one-hot {ld_w, ld_h, ld_hu, ld_b, ld_bu}; all-zero for non-loads.
- `data_sram_rdata`  in  32  SRAM read data; valid only in the first cycle after the load's request (the cycle it first sits valid in MEM).
- `ws_allowin`  in  1  WB can accept.
- `ms2ws_valid`  out  1  MEM presents a valid instruction to WB.
- `ms_pc`  out  32  PC of the MEM instruction.
- `ms_rf_zip`  out  38  {ms_rf_we, ms_rf_waddr[4:0], ms_rf_wdata[31:0]} to WB.
- `ms_fwd_zip`  out  38  {ms_rf_we & ms_valid, ms_rf_waddr, ms_rf_wdata} to decode, for forwarding/hazard checks.

## Operation
- Handshake: ms_ready_go = 1; ms_allowin = ~ms_valid | (ms_ready_go & ws_allowin); ms2ws_valid = ms_valid & ms_ready_go.
- ms_valid: cleared by reset; else when ms_allowin, loaded with es2ms_valid.
- Payload registers (pc, res_from_mem, rf_we, rf_waddr, alu_result, ld_op) load only on es2ms_valid & ms_allowin; otherwise hold.
- Read-data buffer: flag rdata_held clears on every accept and on reset. In a cycle with ms_valid & ~rdata_held: the buffer captures data_sram_rdata and rdata_held sets. Effective word = rdata_held ? buffer : data_sram_rdata.
- Load alignment: off = alu_result[1:0].
  - ld_w: word unchanged; off ignored.
  - ld_b/ld_bu: byte = word[8*off+7 : 8*off]; sign- or zero-extended to 32.
  - ld_h/ld_hu: half = off[1] ? word[31:16] : word[15:0]; off[0] ignored (no misalignment check); sign- or zero-extended.
  - res_from_mem with ld_op all-zero: the full word.
- ms_rf_wdata = res_from_mem ? aligned load value : alu_result.
- ms_rf_zip carries the raw rf_we; WB qualifies it with its own valid. ms_fwd_zip qualifies rf_we with ms_valid.

## Timing
- Reset (resetn low at posedge): ms_valid=0, all payload registers=0, buffer=0, rdata_held=0. Outputs next cycle: ms_allowin=1, ms2ws_valid=0, ms_pc=0, ms_rf_zip=0, ms_fwd_zip=0.
- Latency: one cycle EX→MEM; output is valid in the cycle after accept. With ws_allowin=1, throughput is one instruction per cycle.
- Stall (ws_allowin=0 while ms_valid): ms_allowin=0; payload and outputs hold. A load's wdata stays stable from the SRAM-valid cycle through every stall cycle, driven from the buffer.
- Simultaneous leave/enter: on the same edge the instruction leaves to WB and the next is accepted; rdata_held clears for the new instruction.
- Bubble in (es2ms_valid=0 with ms_allowin=1): ms_valid drops to 0; payload holds stale values; ms_fwd_zip write-enable is 0.
- Reset mid-stall discards the held instruction and buffer.

## Test plan
- Reset, then ALU inst pc=0x1c000000, rf_we=1, waddr=5, alu_result=0x12345678 → next cycle ms2ws_valid=1, ms_rf_zip={1,5,0x12345678}, ms_fwd_zip matches.
- ld_b, address 0x...03, rdata=0x80FF_1234 → wdata=0xFFFFFF80; ld_bu with same inputs → 0x00000080; ld_b with off=1 → 0x00000012.
- ld_h off=2, rdata=0x9ABC_0001 → 0xFFFF9ABC; ld_hu → 0x00009ABC; ld_w off=2 → 0x9ABC0001.
- ld_w with rdata=0xDEADBEEF in the first MEM cycle, ws_allowin=0 for 3 cycles while rdata changes to 0 → wdata stays 0xDEADBEEF, ms_allowin=0, and WB receives it when ws_allowin=1.
- Back-to-back stream of 4 instructions with ws_allowin=1 → one out per cycle, in order; then es2ms_valid=0 → ms2ws_valid=0 and ms_fwd_zip[37]=0.
- resetn low during a stalled load → next cycle all outputs 0, ms_allowin=1.
